// File: rtl/u21_pkg.sv
// Shared pin-code definitions, FSM state type and pin resolution for the u21 sweep block.
package u21_pkg;

  localparam logic [2:0] PIN_O = 3'b000;
  localparam logic [2:0] PIN_I = 3'b001;
  localparam logic [2:0] PIN_A = 3'b010;
  localparam logic [2:0] PIN_B = 3'b011;

  localparam int RSV_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reserved codes (bit 2 set) fall through to the default and drive 0.
  function automatic logic resolve_pin(input logic [2:0] code, input logic a, input logic b);
    logic lvl;
    lvl = 1'b0;
    case (code)
      PIN_O:   lvl = 1'b0;
      PIN_I:   lvl = 1'b1;
      PIN_A:   lvl = a;
      PIN_B:   lvl = b;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/u21_pin_resolve.sv
// Combinational pin resolver: turns a 12-bit wiring word plus (a,b) into four pin levels
// and flags any reserved pin code.
module u21_pin_resolve
  import u21_pkg::*;
(
  input  logic [11:0] i_wiring,
  input  logic        i_a,
  input  logic        i_b,
  output logic [3:0]  o_pins,
  output logic        o_err
);

  always_comb begin
    o_pins = '0;
    o_err  = 1'b0;
    for (int p = 0; p < 4; p++) begin
      o_pins[p] = resolve_pin(i_wiring[3*p +: 3], i_a, i_b);
      o_err     = o_err | i_wiring[3*p + RSV_BIT];
    end
  end

endmodule

// File: rtl/u21_sweep.sv
// Reads a wiring word back to its truth table by sweeping (a,b) through an external gate.
//
//   state | meaning
//   IDLE  | ready for a wiring word, gate pins parked at 0
//   SWEEP | driving combination k for SETTLE cycles, then sampling gate_out into func[k]
//   DONE  | result presented until out_ready
module u21_sweep
  import u21_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_wiring,
  output logic [3:0]  gate_pins,
  input  logic        gate_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_func,
  output logic        out_err
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_wiring;
  logic        r_err;
  logic [3:0]  r_func;
  logic [1:0]  r_k;
  logic [3:0]  r_cnt;
  logic [3:0]  r_out_func;
  logic        r_out_err;

  logic [11:0] w_res_wiring;
  logic [3:0]  w_pins;
  logic        w_err;
  logic        w_accept;
  logic        w_sample;
  logic        w_retire;

  // In IDLE the resolver looks at the incoming word so its err flag can be latched on accept;
  // gate_pins is forced to 0 there, so only the latched word ever reaches the gate.
  assign w_res_wiring = (r_state == IDLE) ? in_wiring : r_wiring;

  u21_pin_resolve u_resolve (
    .i_wiring (w_res_wiring),
    .i_a      (r_k[0]),
    .i_b      (r_k[1]),
    .o_pins   (w_pins),
    .o_err    (w_err)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    gate_pins   = '0;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        gate_pins = w_pins;
        if (r_cnt == CNT_LAST) begin
          w_sample = 1'b1;
          if (r_k == 2'd3) w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The accumulator is cleared on accept, so the last result is parked in r_out_* on retire
  // to keep out_func/out_err steady until the next DONE.
  assign out_func = (r_state == DONE) ? r_func : r_out_func;
  assign out_err  = (r_state == DONE) ? r_err  : r_out_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wiring   <= '0;
      r_err      <= 1'b0;
      r_func     <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_out_func <= '0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wiring <= in_wiring;
        r_err    <= w_err;
        r_func   <= '0;
        r_k      <= '0;
        r_cnt    <= '0;
      end else if (r_state == SWEEP) begin
        if (w_sample) begin
          r_func[r_k] <= gate_out;
          r_cnt       <= '0;
          r_k         <= r_k + 2'd1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if (w_retire) begin
        r_out_func <= r_func;
        r_out_err  <= r_err;
      end
    end
  end

endmodule
